cache_req_arbiter: RTL and testbench

CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

---
 rtl/cache_def.sv | 26 ++
 rtl/arb_rr_pick.sv | 14 +
 rtl/cache_req_arbiter.sv | 89 ++++++++
 tb/tb_cache_req_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// Shared request/result types for the CPU-side cache interface, plus the
// state encoding and default timeout of the two-requester cache arbiter.
package cache_def;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 256;
  localparam int          ARB_CNT_W           = 16;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin select: a lone requester always wins, a tie is
// broken by the round-robin pointer.
module arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic any,
  output logic pick
);

  assign any  = req0 | req1;
  assign pick = (req0 & req1) ? rr_ptr : req1;

endmodule

// File: rtl/cache_req_arbiter.sv
// Arbitrates two CPU requesters onto one cache FSM port, with a bounded wait
// for the cache result and a sticky timeout flag.
module cache_req_arbiter
  import cache_def::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  cpu_req_type    cpu_req0,
  input  cpu_req_type    cpu_req1,
  output cpu_result_type cpu_res0,
  output cpu_result_type cpu_res1,
  output cpu_req_type    cache_req,
  input  cpu_result_type cache_res,
  output logic           gnt_id,
  output logic           busy,
  output logic           timeout_err
);

  // Last count value before abort: WAIT lasts at most TIMEOUT_CYCLES cycles.
  localparam logic [ARB_CNT_W-1:0] CNT_MAX = ARB_CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e           state;
  logic                 rr_ptr;
  logic [ARB_CNT_W-1:0] wait_cnt;
  logic [31:0]          resp_data;
  logic                 req_any;
  logic                 req_pick;

  arb_rr_pick u_pick (
    .req0   (cpu_req0.valid),
    .req1   (cpu_req1.valid),
    .rr_ptr (rr_ptr),
    .any    (req_any),
    .pick   (req_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      rr_ptr      <= 1'b0;
      gnt_id      <= 1'b0;
      wait_cnt    <= '0;
      cache_req   <= '0;
      resp_data   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (req_any) begin
            gnt_id          <= req_pick;
            cache_req.addr  <= req_pick ? cpu_req1.addr : cpu_req0.addr;
            cache_req.data  <= req_pick ? cpu_req1.data : cpu_req0.data;
            cache_req.rw    <= req_pick ? cpu_req1.rw   : cpu_req0.rw;
            cache_req.valid <= 1'b1;
            wait_cnt        <= '0;
            state           <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // A result arriving on the final allowed cycle beats the timeout.
          if (cache_res.ready) begin
            resp_data       <= cache_res.data;
            cache_req.valid <= 1'b0;
            state           <= ARB_RESP;
          end else if (wait_cnt == CNT_MAX) begin
            resp_data       <= '0;
            timeout_err     <= 1'b1;
            cache_req.valid <= 1'b0;
            state           <= ARB_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ARB_RESP: begin
          rr_ptr <= ~gnt_id;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy     = (state != ARB_IDLE);
  assign cpu_res0 = '{data: resp_data, ready: (state == ARB_RESP) && !gnt_id};
  assign cpu_res1 = '{data: resp_data, ready: (state == ARB_RESP) &&  gnt_id};

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: a transaction-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_cache_req_arbiter;
  import cache_def::*;

  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  cpu_req_type    cpu_req0 = '0;
  cpu_req_type    cpu_req1 = '0;
  cpu_result_type cpu_res0;
  cpu_result_type cpu_res1;
  cpu_req_type    cache_req;
  cpu_result_type cache_res = '0;
  logic           gnt_id;
  logic           busy;
  logic           timeout_err;

  int errors = 0;
  int checks = 0;

  cache_req_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req0    (cpu_req0),
    .cpu_req1    (cpu_req1),
    .cpu_res0    (cpu_res0),
    .cpu_res1    (cpu_res1),
    .cache_req   (cache_req),
    .cache_res   (cache_res),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no transaction, 1 = waiting on cache, 2 = answering.
  int          m_phase = 0;
  int          m_waited = 0;
  bit          m_rr = 1'b0;
  bit          m_gnt = 1'b0;
  cpu_req_type m_req = '0;
  logic [31:0] m_data = '0;
  bit          m_terr = 1'b0;

  function automatic bit winner(input bit v0, input bit v1, input bit rr);
    if (v0 && v1) return rr;
    return v1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_waited <= 0; m_rr <= 1'b0; m_gnt <= 1'b0;
      m_req <= '0; m_data <= '0; m_terr <= 1'b0;
    end else begin
      case (m_phase)
        0: if (cpu_req0.valid || cpu_req1.valid) begin
          m_gnt    <= winner(cpu_req0.valid, cpu_req1.valid, m_rr);
          m_req    <= winner(cpu_req0.valid, cpu_req1.valid, m_rr) ? cpu_req1 : cpu_req0;
          m_waited <= 0;
          m_phase  <= 1;
        end
        1: begin
          if (cache_res.ready) begin
            m_data <= cache_res.data; m_phase <= 2;
          end else if (m_waited + 1 == TMO) begin
            m_data <= '0; m_terr <= 1'b1; m_phase <= 2;
          end else begin
            m_waited <= m_waited + 1;
          end
        end
        default: begin
          m_rr    <= !m_gnt;
          m_phase <= 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      chk("cache_req.valid", 32'(cache_req.valid), 32'(m_phase == 1));
      chk("cache_req.addr",  cache_req.addr, m_req.addr);
      chk("cache_req.data",  cache_req.data, m_req.data);
      chk("cache_req.rw",    32'(cache_req.rw), 32'(m_req.rw));
      chk("res0.ready",      32'(cpu_res0.ready), 32'(m_phase == 2 && !m_gnt));
      chk("res1.ready",      32'(cpu_res1.ready), 32'(m_phase == 2 && m_gnt));
      chk("res0.data",       cpu_res0.data, m_data);
      chk("res1.data",       cpu_res1.data, m_data);
      chk("gnt_id",          32'(gnt_id), 32'(m_gnt));
      chk("busy",            32'(busy), 32'(m_phase != 0));
      chk("timeout_err",     32'(timeout_err), 32'(m_terr));
      if (cpu_res0.ready || cpu_res1.ready)
        $display("txn: requester %0d data=%h timeout_err=%0b", cpu_res1.ready, cpu_res0.data, timeout_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic serve(input int idle_cycles, input logic [31:0] d);
    repeat (idle_cycles) @(negedge clk);
    cache_res = '{data: d, ready: 1'b1};
    @(negedge clk);
    cache_res = '0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".gnt_id"}, 32'(gnt_id), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".cache_req.valid"}, 32'(cache_req.valid), 32'd0);
    chk({tag, ".cache_req.addr"}, cache_req.addr, 32'd0);
    chk({tag, ".res_ready"}, 32'({cpu_res1.ready, cpu_res0.ready}), 32'd0);
    chk({tag, ".res_data"}, cpu_res0.data | cpu_res1.data, 32'd0);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 0; drops valid during WAIT
    cpu_req0 = '{addr: 32'h0000_0040, data: 32'h1111_2222, rw: 1'b0, valid: 1'b1};
    chk("single.pre_valid", 32'(cache_req.valid), 32'd0);
    @(negedge clk);
    chk("single.latency_valid", 32'(cache_req.valid), 32'd1);
    chk("single.addr", cache_req.addr, 32'h0000_0040);
    cpu_req0.valid = 1'b0;
    serve(2, 32'hDEAD_BEEF);
    chk("single.res0_ready", 32'(cpu_res0.ready), 32'd1);
    chk("single.res0_data", cpu_res0.data, 32'hDEAD_BEEF);
    chk("single.res1_ready", 32'(cpu_res1.ready), 32'd0);
    @(negedge clk);
    chk("single.after_ready", 32'(cpu_res0.ready), 32'd0);
    chk("single.data_held", cpu_res0.data, 32'hDEAD_BEEF);

    // Stray cache ready while idle is ignored
    cache_res = '{data: 32'h5555_5555, ready: 1'b1};
    @(negedge clk);
    cache_res = '0;
    chk("stray.busy", 32'(busy), 32'd0);
    chk("stray.data", cpu_res0.data, 32'hDEAD_BEEF);

    // Contention from reset: strict alternation 0,1,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cpu_req0 = '{addr: 32'h0000_1000, data: 32'h0, rw: 1'b1, valid: 1'b1};
    cpu_req1 = '{addr: 32'h0000_2000, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rr.gnt_id", 32'(gnt_id), 32'(k % 2));
      chk("rr.addr", cache_req.addr, (k % 2) ? 32'h0000_2000 : 32'h0000_1000);
      serve(0, 32'hA000_0000 + 32'(k));
      chk("rr.ready_side", 32'({cpu_res1.ready, cpu_res0.ready}), (k % 2) ? 32'd2 : 32'd1);
      chk("rr.data", cpu_res0.data, 32'hA000_0000 + 32'(k));
      @(negedge clk);
      @(negedge clk);
    end
    cpu_req0.valid = 1'b0;
    cpu_req1.valid = 1'b0;
    serve(0, 32'h0);
    @(negedge clk);

    // Latch stability: requester 1 changes its address mid-WAIT
    cpu_req1 = '{addr: 32'h0000_0100, data: 32'h7777_0000, rw: 1'b1, valid: 1'b1};
    @(negedge clk);
    cpu_req1.addr  = 32'h0000_0200;
    cpu_req1.valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("latch.addr", cache_req.addr, 32'h0000_0100);
      @(negedge clk);
    end
    chk("latch.addr_last", cache_req.addr, 32'h0000_0100);
    serve(0, 32'h0BAD_F00D);
    chk("latch.res1_ready", 32'(cpu_res1.ready), 32'd1);
    @(negedge clk);

    // Timeout: cache never answers
    cpu_req0 = '{addr: 32'h0000_0300, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    cpu_req0.valid = 1'b0;
    repeat (TMO - 1) @(negedge clk);
    chk("tmo.still_wait", 32'(cache_req.valid), 32'd1);
    chk("tmo.no_err_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("tmo.res0_ready", 32'(cpu_res0.ready), 32'd1);
    chk("tmo.data_zero", cpu_res0.data, 32'd0);
    chk("tmo.err", 32'(timeout_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("tmo.err_sticky", 32'(timeout_err), 32'd1);

    // Reset mid-WAIT at WAIT cycle 2
    cpu_req1 = '{addr: 32'h0000_0400, data: 32'h0, rw: 1'b1, valid: 1'b1};
    @(negedge clk);
    cpu_req1.valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_values("midwait");
    @(negedge clk);
    rst = 1'b0;
    cache_res = '{data: 32'h1234_5678, ready: 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midwait.no_pulse", 32'({cpu_res1.ready, cpu_res0.ready}), 32'd0);
    end
    cache_res = '0;

    // Ready on the final allowed WAIT cycle wins over timeout
    cpu_req0 = '{addr: 32'h0000_0500, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    cpu_req0.valid = 1'b0;
    serve(TMO - 1, 32'hCAFE_F00D);
    chk("race.res0_ready", 32'(cpu_res0.ready), 32'd1);
    chk("race.data", cpu_res0.data, 32'hCAFE_F00D);
    chk("race.no_err", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    chk("race.idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
